// File: rtl/uart_receiver.sv
// UART receive stage: synchronizes rx, frames start/data/stop bits and hands bytes out on
// valid/ready. Optional define UART_RX_MAJORITY_EN enables 3-sample majority voting.
module uart_receiver #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] clocksPerCycle,
  input  logic [3:0]  bitsPerFrame,
  input  logic        rxDataReady,
  output logic        rxDataValid,
  output logic [7:0]  rxData,
  output logic        framingError,
  output logic        overrunError
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;
  logic        ferr_q, ferr_d;
  logic        oerr_q, oerr_d;

  logic [15:0] c_val;
  logic [15:0] c_half;
  logic [15:0] h_val;
  logic [3:0]  n_val;
  logic        sample_bit;
  logic        deliver;
  logic        frame_err;
  logic [7:0]  rx_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  // Vote over rxs one cycle before, at, and after the sample point. The "after" value is taken
  // from the preceding synchronizer stage so the decision cycle, and thus latency, is unchanged.
  logic rxs_prev_q;
  logic rx_ahead;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxs_prev_q <= 1'b1;
    end else begin
      rxs_prev_q <= rxs;
    end
  end

  assign rx_ahead   = sync_q[SYNC_STAGES-2];
  assign sample_bit = (rx_ahead & rxs) | (rx_ahead & rxs_prev_q) | (rxs & rxs_prev_q);
`else
  assign sample_bit = rxs;
`endif

  always_comb begin
    c_val  = (clocksPerCycle == 16'd0) ? 16'd1 : clocksPerCycle;
    c_half = c_val >> 1;
    h_val  = (c_half == 16'd0) ? 16'd1 : c_half;
    if (bitsPerFrame == 4'd0) begin
      n_val = 4'd1;
    end else if (bitsPerFrame > 4'd8) begin
      n_val = 4'd8;
    end else begin
      n_val = bitsPerFrame;
    end
  end

  // Data arrives LSB first into the top of shreg; right-align the N received bits.
  assign rx_byte = shreg_q >> (4'd8 - n_val);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    deliver   = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d = StStart;
          cnt_d   = 16'd1;
          shreg_d = 8'h00;
        end
      end
      StStart: begin
        if (cnt_q == h_val) begin
          if (!sample_bit) begin
            state_d = StData;
            cnt_d   = 16'd1;
            idx_d   = 4'd1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (cnt_q >= c_val) begin
          shreg_d = {sample_bit, shreg_q[7:1]};
          cnt_d   = 16'd1;
          if (idx_q >= n_val) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (cnt_q >= c_val) begin
          if (sample_bit) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err = 1'b1;
            state_d   = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StBreak: begin
        if (rxs) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ferr_d  = frame_err;
    oerr_d  = 1'b0;
    if (valid_q && rxDataReady) begin
      valid_d = 1'b0;
      data_d  = 8'h00;
    end
    // A consume in the same cycle frees the buffer for the new byte.
    if (deliver) begin
      if (!valid_q || rxDataReady) begin
        valid_d = 1'b1;
        data_d  = rx_byte;
      end else begin
        oerr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 16'd1;
      idx_q   <= 4'd1;
      shreg_q <= 8'h00;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  assign rxDataValid  = valid_q;
  assign rxData       = data_q;
  assign framingError = ferr_q;
  assign overrunError = oerr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: stimulus pushes expected events, a monitor pops them
// as bytes are consumed or error pulses appear.
module tb_uart_receiver;

  localparam int KindData = 0;
  localparam int KindFerr = 1;
  localparam int KindOerr = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic        clk;
  logic        reset;
  logic        rx;
  logic [15:0] cpc;
  logic [3:0]  bpf;
  logic        ready;
  logic        valid;
  logic [7:0]  data;
  logic        ferr;
  logic        oerr;

  ev_t exp_q[$];
  int  n_checks;
  int  n_fails;

  uart_receiver #(
    .SYNC_STAGES(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .clocksPerCycle(cpc),
    .bitsPerFrame  (bpf),
    .rxDataReady   (ready),
    .rxDataValid   (valid),
    .rxData        (data),
    .framingError  (ferr),
    .overrunError  (oerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ev(input int kind, input logic [7:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fails++;
      $display("FAIL unexpected_event: got kind %0d data %0h expected none", kind, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == KindData && e.data !== d)) begin
        n_fails++;
        $display("FAIL event: got kind %0d data %0h expected kind %0d data %0h",
                 kind, d, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (valid && ready) check_ev(KindData, data);
      if (ferr) check_ev(KindFerr, 8'h00);
      if (oerr) check_ev(KindOerr, 8'h00);
    end
  end

  task automatic push(input int kind, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    for (int i = 0; i < int'(cpc); i++) begin
      rx = (glitch && i == int'(cpc) / 2) ? ~b : b;
      tick(1);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input logic stop, input int gbit);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < n; i++) drive_bit(d[i], i == gbit);
    drive_bit(stop, 1'b0);
    rx = 1'b1;
  endtask

  task automatic pulse_ready;
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b1;
    rx       = 1'b1;
    cpc      = 16'd16;
    bpf      = 4'd8;
    ready    = 1'b0;
    tick(3);
    @(negedge clk);
    check("reset_valid", {15'd0, valid}, 16'd0);
    check("reset_data", {8'd0, data}, 16'd0);
    check("reset_ferr", {15'd0, ferr}, 16'd0);
    check("reset_oerr", {15'd0, oerr}, 16'd0);
    reset = 1'b0;
    tick(4);

    // Byte held in buffer while ready is low.
    push(KindData, 8'h55);
    send_frame(8'h55, 8, 1'b1, -1);
    tick(20);
    @(negedge clk);
    check("hold_valid", {15'd0, valid}, 16'd1);
    check("hold_data", {8'd0, data}, 16'h0055);
    tick(1);
    pulse_ready();
    @(negedge clk);
    check("consumed_valid", {15'd0, valid}, 16'd0);
    tick(4);

    // Back-to-back frames with ready tied high.
    ready = 1'b1;
    push(KindData, 8'hA3);
    send_frame(8'hA3, 8, 1'b1, -1);
    push(KindData, 8'h0F);
    send_frame(8'h0F, 8, 1'b1, -1);
    push(KindData, 8'hFF);
    send_frame(8'hFF, 8, 1'b1, -1);
    tick(8);
    ready = 1'b0;

    // Overrun: second byte dropped, first kept.
    send_frame(8'h11, 8, 1'b1, -1);
    tick(4);
    push(KindOerr, 8'h00);
    send_frame(8'h22, 8, 1'b1, -1);
    tick(8);
    @(negedge clk);
    check("overrun_keep_data", {8'd0, data}, 16'h0011);
    tick(1);
    push(KindData, 8'h11);
    pulse_ready();
    tick(4);

    // Framing error followed by a held-low line.
    ready = 1'b1;
    push(KindFerr, 8'h00);
    send_frame(8'h3C, 8, 1'b0, -1);
    rx = 1'b0;
    tick(40);
    rx = 1'b1;
    tick(40);
    @(negedge clk);
    check("ferr_no_valid", {15'd0, valid}, 16'd0);
    tick(1);

    // Short low glitch is a false start.
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(48);

    // Narrow frames.
    bpf = 4'd5;
    push(KindData, 8'h13);
    send_frame(8'h13, 5, 1'b1, -1);
    tick(4);
    bpf = 4'd0;
    push(KindData, 8'h01);
    send_frame(8'h01, 1, 1'b1, -1);
    tick(4);
    bpf = 4'd8;

    // Reset during DATA drops the partial frame.
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    reset = 1'b1;
    rx    = 1'b1;
    tick(2);
    @(negedge clk);
    check("midreset_valid", {15'd0, valid}, 16'd0);
    check("midreset_data", {8'd0, data}, 16'd0);
    tick(1);
    reset = 1'b0;
    tick(40);
    push(KindData, 8'h7E);
    send_frame(8'h7E, 8, 1'b1, -1);
    tick(4);

`ifdef UART_RX_MAJORITY_EN
    push(KindData, 8'hA5);
    send_frame(8'hA5, 8, 1'b1, 3);
    tick(4);
`endif

    tick(40);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
